hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter FWD_EN, default 1: 1 = forward to EX plus load-use stall; 0 = stall-only, no forwarding.
REQ-002 SHALL have parameter RF_WR_FIRST, default 1: 1 = register file bypasses same-cycle writes, so WB is excluded from stall checks; 0 = WB is included.
REQ-003 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-004 SHALL have parameter MAX_STALL, default 4: consecutive-stall limit before the error flag sets.
REQ-005 SHALL have port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port i_reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports instr_id, instr_ex, instr_mem, instr_wb, input, 32 each: instruction held in each pipeline register.
REQ-008 SHALL have ports rd_wren_ex, rd_wren_mem, rd_wren_wb, input, 1 each: stage writes rd.
REQ-009 SHALL have port pc_sel_ex, input, 1: branch/jump taken, resolved in EX.
REQ-010 SHALL have ports o_enable_pc, o_enable_if, output, 1 each: PC and IF/ID register load enables.
REQ-011 SHALL have ports o_flush_if, o_flush_id, output, 1 each, active-high: insert a bubble into IF/ID and ID/EX respectively.
REQ-012 SHALL have ports o_fwd_a_sel, o_fwd_b_sel, output, 2 each: EX operand source (00 = register file, 01 = MEM ALU result, 10 = WB data).
REQ-013 SHALL have ports o_hazard, output, 1; o_err, output, 1 (sticky); o_stall_cnt, output, CNT_W; o_flush_cnt, output, CNT_W.

Function
REQ-014 SHALL decode fields as rs1 = [19:15], rs2 = [24:20], rd = [11:7].
REQ-015 SHALL treat rs1 as used by all opcodes except LUI, AUIPC and JAL.
REQ-016 SHALL treat rs2 as used only by R-type, S-type and B-type instructions.
REQ-017 SHALL treat rd = x0 as never producing a hazard or a forward.
REQ-018 SHALL, when FWD_EN=0, raise o_hazard when a used ID source equals rd of EX, MEM, or (if RF_WR_FIRST=0) WB, and that stage's rd_wren is 1.
REQ-019 SHALL, when FWD_EN=1, raise o_hazard only on load-use: instr_ex opcode is 0000011, rd_wren_ex=1, and rd_ex equals a used ID source.
REQ-020 SHALL, when FWD_EN=1, give MEM priority over WB when setting o_fwd_*_sel for each used EX source; otherwise 00.
REQ-021 SHALL hold o_fwd_*_sel at 00 when FWD_EN=0.
REQ-022 SHALL, on a stall (o_hazard=1 and pc_sel_ex=0), drive o_enable_pc=0, o_enable_if=0, o_flush_id=1, o_flush_if=0.
REQ-023 SHALL, when pc_sel_ex=1, drive o_flush_if=1, o_flush_id=1, o_enable_pc=1, o_enable_if=1, overriding any hazard.
REQ-024 SHALL drive every control output combinationally from the current inputs, with zero-cycle latency.
REQ-025 SHALL implement a registered FSM with states RUN, STALL and FLUSH.
REQ-026 SHALL transition to FLUSH from any state when pc_sel_ex=1.
REQ-027 SHALL transition to STALL from any state on a stall.
REQ-028 SHALL transition to RUN otherwise.
REQ-029 SHALL keep a consecutive-stall counter that increments in STALL and clears on leaving STALL.
REQ-030 SHALL set o_err when the consecutive-stall count exceeds MAX_STALL; o_err clears only on reset.
REQ-031 SHALL increment o_stall_cnt on each stall cycle and o_flush_cnt on each cycle with pc_sel_ex=1, both saturating at 2^CNT_W-1 with no wrap.

Reset
REQ-032 SHALL, while i_reset=0, asynchronously force: FSM = RUN, counters = 0, o_err = 0.
REQ-033 SHALL, while i_reset=0, force o_enable_pc/if = 1, o_flush_* = 0, o_fwd_* = 00, o_hazard = 0, regardless of inputs.
REQ-034 SHALL resume normal operation on the first rising edge after deassertion.
REQ-035 SHALL, on a reset asserted mid-stall, drop the stall immediately and discard the consecutive-stall count.

Verification
REQ-036 SHALL verify FWD_EN=0, RF_WR_FIRST=1: 0x00100293 (addi x5,x0,1) followed by 0x00528333 (add x6,x5,x5) -> exactly 2 stall cycles, o_stall_cnt=2.
REQ-037 SHALL verify FWD_EN=0, RF_WR_FIRST=0, MAX_STALL=2: same pair -> 3 stall cycles, o_err=1 after the third.
REQ-038 SHALL verify FWD_EN=1: same pair -> no stall; with add in EX and addi in MEM, o_fwd_a_sel=o_fwd_b_sel=01.
REQ-039 SHALL verify FWD_EN=1: 0x00002283 (lw x5,0(x0)) then add -> 1 stall cycle, then o_fwd_a_sel=o_fwd_b_sel=10.
REQ-040 SHALL verify hazard and pc_sel_ex=1 in the same cycle -> o_flush_if=o_flush_id=1, o_enable_pc=1, o_flush_cnt+1, o_stall_cnt unchanged.
REQ-041 SHALL verify: 0x00100013 (addi x0,x0,1) then 0x00000333 (add x6,x0,x0) -> no stall and fwd=00; also CNT_W=2 with 5 flushes -> o_flush_cnt=3.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for a 5-stage RV32 pipeline.
// Drives stall/flush enables, EX bypass selects and stall/flush counters.
//
// Ports:
//   i_clk, i_reset       clock, async active-low reset
//   instr_id..instr_wb   instruction held in each pipeline register
//   rd_wren_ex/mem/wb    stage will write its rd
//   pc_sel_ex            branch/jump taken, resolved in EX
//   o_enable_pc/if       PC and IF/ID load enables
//   o_flush_if/id        bubble into IF/ID and ID/EX
//   o_fwd_a/b_sel        EX operand source: 00 RF, 01 MEM, 10 WB
//   o_hazard             raw hazard indication
//   o_err                sticky: too many consecutive stalls
//   o_stall_cnt          saturating stall-cycle count
//   o_flush_cnt          saturating taken-branch count
module hazard_fwd_unit #(
   parameter int FWD_EN      = 1,
   parameter int RF_WR_FIRST = 1,
   parameter int CNT_W       = 16,
   parameter int MAX_STALL   = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [31:0]      instr_id,
   input  logic [31:0]      instr_ex,
   input  logic [31:0]      instr_mem,
   input  logic [31:0]      instr_wb,
   input  logic             rd_wren_ex,
   input  logic             rd_wren_mem,
   input  logic             rd_wren_wb,
   input  logic             pc_sel_ex,
   output logic             o_enable_pc,
   output logic             o_enable_if,
   output logic             o_flush_if,
   output logic             o_flush_id,
   output logic [1:0]       o_fwd_a_sel,
   output logic [1:0]       o_fwd_b_sel,
   output logic             o_hazard,
   output logic             o_err,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;

   // Run-length counter only needs to reach one past the limit.
   localparam int CW = $clog2(MAX_STALL + 2);
   localparam logic [CW-1:0] RUN_SAT = CW'(MAX_STALL + 1);
   localparam logic [CW-1:0] RUN_THR = CW'(MAX_STALL);

   typedef enum logic [1:0] {
      RUN,
      STALL,
      FLUSH
   } state_t;

   function automatic logic uses_rs1(input logic [6:0] op);
      return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_R) || (op == OP_S) || (op == OP_B);
   endfunction

   function automatic logic hit(
      input logic       used,
      input logic [4:0] src,
      input logic       wr,
      input logic [4:0] rd
   );
      return used && wr && (src == rd);
   endfunction

   // MEM holds the younger result, so it wins over WB.
   function automatic logic [1:0] fwd_sel(
      input logic       used,
      input logic [4:0] src,
      input logic       wr_m,
      input logic [4:0] rd_m,
      input logic       wr_w,
      input logic [4:0] rd_w
   );
      logic [1:0] s;
      s = 2'b00;
      if (hit(used, src, wr_m, rd_m)) begin
         s = 2'b01;
      end else if (hit(used, src, wr_w, rd_w)) begin
         s = 2'b10;
      end
      return s;
   endfunction

   logic [4:0] rs1_id;
   logic [4:0] rs2_id;
   logic [4:0] rs1_ex;
   logic [4:0] rs2_ex;
   logic [4:0] rd_ex;
   logic [4:0] rd_mem;
   logic [4:0] rd_wb;
   logic       u1_id;
   logic       u2_id;
   logic       u1_ex;
   logic       u2_ex;
   logic       wr_ex;
   logic       wr_mem;
   logic       wr_wb;
   logic       load_ex;
   logic       hit_ex;
   logic       hit_mem;
   logic       hit_wb;
   logic       haz_raw;
   logic       stall;
   logic       flush;

   state_t          state_q;
   state_t          state_d;
   logic [CW-1:0]   run_q;
   logic [CW-1:0]   run_d;
   logic            err_q;
   logic            err_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d;

   logic unused_ok;

   assign rs1_id = instr_id[19:15];
   assign rs2_id = instr_id[24:20];
   assign rs1_ex = instr_ex[19:15];
   assign rs2_ex = instr_ex[24:20];
   assign rd_ex  = instr_ex[11:7];
   assign rd_mem = instr_mem[11:7];
   assign rd_wb  = instr_wb[11:7];

   assign u1_id = uses_rs1(instr_id[6:0]);
   assign u2_id = uses_rs2(instr_id[6:0]);
   assign u1_ex = uses_rs1(instr_ex[6:0]);
   assign u2_ex = uses_rs2(instr_ex[6:0]);

   // x0 destinations never create a dependency.
   assign wr_ex  = rd_wren_ex  && (rd_ex  != 5'd0);
   assign wr_mem = rd_wren_mem && (rd_mem != 5'd0);
   assign wr_wb  = rd_wren_wb  && (rd_wb  != 5'd0);

   assign load_ex = (instr_ex[6:0] == OP_LOAD);

   assign hit_ex  = hit(u1_id, rs1_id, wr_ex, rd_ex)
                  | hit(u2_id, rs2_id, wr_ex, rd_ex);
   assign hit_mem = hit(u1_id, rs1_id, wr_mem, rd_mem)
                  | hit(u2_id, rs2_id, wr_mem, rd_mem);
   assign hit_wb  = hit(u1_id, rs1_id, wr_wb, rd_wb)
                  | hit(u2_id, rs2_id, wr_wb, rd_wb);

   always_comb begin
      haz_raw = 1'b0;
      if (FWD_EN != 0) begin
         haz_raw = load_ex && hit_ex;
      end else begin
         haz_raw = hit_ex || hit_mem
                || ((RF_WR_FIRST == 0) && hit_wb);
      end
   end

   // Reset masks everything so a mid-stall reset drops the stall.
   assign stall = i_reset && haz_raw && !pc_sel_ex;
   assign flush = i_reset && pc_sel_ex;

   always_comb begin
      o_enable_pc = 1'b1;
      o_enable_if = 1'b1;
      o_flush_if  = 1'b0;
      o_flush_id  = 1'b0;
      o_hazard    = 1'b0;
      o_fwd_a_sel = 2'b00;
      o_fwd_b_sel = 2'b00;
      if (i_reset) begin
         o_hazard = haz_raw;
         if (FWD_EN != 0) begin
            o_fwd_a_sel = fwd_sel(u1_ex, rs1_ex, wr_mem, rd_mem,
                                  wr_wb, rd_wb);
            o_fwd_b_sel = fwd_sel(u2_ex, rs2_ex, wr_mem, rd_mem,
                                  wr_wb, rd_wb);
         end
         if (pc_sel_ex) begin
            o_flush_if = 1'b1;
            o_flush_id = 1'b1;
         end else if (haz_raw) begin
            o_enable_pc = 1'b0;
            o_enable_if = 1'b0;
            o_flush_id  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = RUN;
      run_d       = '0;
      err_d       = err_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (flush) begin
         state_d = FLUSH;
      end else if (stall) begin
         state_d = STALL;
      end
      if (stall) begin
         if (state_q != STALL) begin
            run_d = CW'(1);
         end else if (run_q != RUN_SAT) begin
            run_d = run_q + CW'(1);
         end else begin
            run_d = run_q;
         end
      end
      if (run_d > RUN_THR) begin
         err_d = 1'b1;
      end
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= RUN;
         run_q       <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign o_err       = err_q;
   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;

   assign unused_ok = ^{instr_id[31:25], instr_id[14:7],
                        instr_ex[31:25], instr_ex[14:12],
                        instr_mem[31:12], instr_mem[6:0],
                        instr_wb[31:12], instr_wb[6:0]};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit across four parameter sets.
// Driver queues hand-computed expectations; monitor checks each cycle.
module tb_hazard_fwd_unit;

   localparam logic [31:0] ADDI   = 32'h00100293;
   localparam logic [31:0] ADD    = 32'h00528333;
   localparam logic [31:0] LW     = 32'h00002283;
   localparam logic [31:0] NOP    = 32'h00000013;
   localparam logic [31:0] ADDIX0 = 32'h00100013;
   localparam logic [31:0] ADD0   = 32'h00000333;

   // {enable_pc, enable_if, flush_if, flush_id}
   localparam logic [3:0] RUN = 4'b1100;
   localparam logic [3:0] STL = 4'b0001;
   localparam logic [3:0] FLS = 4'b1111;

   typedef struct {
      int          d;
      string       nm;
      logic [41:0] e;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] iid = '0;
   logic [31:0] iex = '0;
   logic [31:0] imem = '0;
   logic [31:0] iwb = '0;
   logic        wex = 1'b0;
   logic        wmem = 1'b0;
   logic        wwb = 1'b0;
   logic        pcs = 1'b0;

   logic [3:0]  enpc, enif, flif, flid, haz, err;
   logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2, fa3, fb3;
   logic [15:0] sc0, fc0, sc1, fc1, sc2, fc2;
   logic [1:0]  sc3, fc3;

   always #5 clk = ~clk;

   hazard_fwd_unit #(.FWD_EN(0), .RF_WR_FIRST(1)) u0 (
      .i_clk(clk), .i_reset(rst_n),
      .instr_id(iid), .instr_ex(iex),
      .instr_mem(imem), .instr_wb(iwb),
      .rd_wren_ex(wex), .rd_wren_mem(wmem),
      .rd_wren_wb(wwb), .pc_sel_ex(pcs),
      .o_enable_pc(enpc[0]), .o_enable_if(enif[0]),
      .o_flush_if(flif[0]), .o_flush_id(flid[0]),
      .o_fwd_a_sel(fa0), .o_fwd_b_sel(fb0),
      .o_hazard(haz[0]), .o_err(err[0]),
      .o_stall_cnt(sc0), .o_flush_cnt(fc0)
   );

   hazard_fwd_unit #(.FWD_EN(0), .RF_WR_FIRST(0),
                     .MAX_STALL(2)) u1 (
      .i_clk(clk), .i_reset(rst_n),
      .instr_id(iid), .instr_ex(iex),
      .instr_mem(imem), .instr_wb(iwb),
      .rd_wren_ex(wex), .rd_wren_mem(wmem),
      .rd_wren_wb(wwb), .pc_sel_ex(pcs),
      .o_enable_pc(enpc[1]), .o_enable_if(enif[1]),
      .o_flush_if(flif[1]), .o_flush_id(flid[1]),
      .o_fwd_a_sel(fa1), .o_fwd_b_sel(fb1),
      .o_hazard(haz[1]), .o_err(err[1]),
      .o_stall_cnt(sc1), .o_flush_cnt(fc1)
   );

   hazard_fwd_unit #(.FWD_EN(1)) u2 (
      .i_clk(clk), .i_reset(rst_n),
      .instr_id(iid), .instr_ex(iex),
      .instr_mem(imem), .instr_wb(iwb),
      .rd_wren_ex(wex), .rd_wren_mem(wmem),
      .rd_wren_wb(wwb), .pc_sel_ex(pcs),
      .o_enable_pc(enpc[2]), .o_enable_if(enif[2]),
      .o_flush_if(flif[2]), .o_flush_id(flid[2]),
      .o_fwd_a_sel(fa2), .o_fwd_b_sel(fb2),
      .o_hazard(haz[2]), .o_err(err[2]),
      .o_stall_cnt(sc2), .o_flush_cnt(fc2)
   );

   hazard_fwd_unit #(.FWD_EN(1), .CNT_W(2)) u3 (
      .i_clk(clk), .i_reset(rst_n),
      .instr_id(iid), .instr_ex(iex),
      .instr_mem(imem), .instr_wb(iwb),
      .rd_wren_ex(wex), .rd_wren_mem(wmem),
      .rd_wren_wb(wwb), .pc_sel_ex(pcs),
      .o_enable_pc(enpc[3]), .o_enable_if(enif[3]),
      .o_flush_if(flif[3]), .o_flush_id(flid[3]),
      .o_fwd_a_sel(fa3), .o_fwd_b_sel(fb3),
      .o_hazard(haz[3]), .o_err(err[3]),
      .o_stall_cnt(sc3), .o_flush_cnt(fc3)
   );

   function automatic logic [41:0] act(input int d);
      logic [41:0] r;
      case (d)
         0: r = {haz[0], enpc[0], enif[0], flif[0], flid[0],
                 fa0, fb0, err[0], sc0, fc0};
         1: r = {haz[1], enpc[1], enif[1], flif[1], flid[1],
                 fa1, fb1, err[1], sc1, fc1};
         2: r = {haz[2], enpc[2], enif[2], flif[2], flid[2],
                 fa2, fb2, err[2], sc2, fc2};
         default: r = {haz[3], enpc[3], enif[3], flif[3],
                       flid[3], fa3, fb3, err[3],
                       14'd0, sc3, 14'd0, fc3};
      endcase
      return r;
   endfunction

   task automatic drive(
      input int          d,
      input string       nm,
      input logic [31:0] id,
      input logic [31:0] ex,
      input logic [31:0] mem,
      input logic [31:0] wb,
      input logic [2:0]  w,
      input logic        pc,
      input logic        h,
      input logic [3:0]  c,
      input logic [1:0]  a,
      input logic [1:0]  b,
      input logic        er,
      input int          sc,
      input int          fc
   );
      exp_t x;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      iid = id;
      iex = ex;
      imem = mem;
      iwb = wb;
      {wex, wmem, wwb} = w;
      pcs = pc;
      x.d  = d;
      x.nm = nm;
      x.e  = {h, c, a, b, er, 16'(sc), 16'(fc)};
      q.push_back(x);
   endtask

   // One cycle with reset held low under hazardous inputs.
   task automatic rst(input int d, input string nm,
                      input logic pc);
      exp_t x;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      iid = ADD;
      iex = LW;
      imem = ADDI;
      iwb = ADDI;
      {wex, wmem, wwb} = 3'b111;
      pcs = pc;
      x.d  = d;
      x.nm = nm;
      x.e  = {1'b0, RUN, 2'b00, 2'b00, 1'b0, 16'd0, 16'd0};
      q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t x;
         logic [41:0] a;
         x = q.pop_front();
         a = act(x.d);
         n_cmp++;
         if (a !== x.e) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h want %h",
                     x.nm, x.d, a, x.e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);

      rst(0, "rstA", 1'b0);
      drive(0, "A1", ADD, ADDI, NOP, NOP, 3'b100, 0,
            1, STL, 0, 0, 0, 0, 0);
      drive(0, "A2", ADD, NOP, ADDI, NOP, 3'b010, 0,
            1, STL, 0, 0, 0, 1, 0);
      drive(0, "A3", ADD, NOP, NOP, ADDI, 3'b001, 0,
            0, RUN, 0, 0, 0, 2, 0);
      drive(0, "A4", NOP, ADD, NOP, NOP, 3'b100, 0,
            0, RUN, 0, 0, 0, 2, 0);

      rst(1, "rstB", 1'b0);
      drive(1, "B1", ADD, ADDI, NOP, NOP, 3'b100, 0,
            1, STL, 0, 0, 0, 0, 0);
      drive(1, "B2", ADD, NOP, ADDI, NOP, 3'b010, 0,
            1, STL, 0, 0, 0, 1, 0);
      drive(1, "B3", ADD, NOP, NOP, ADDI, 3'b001, 0,
            1, STL, 0, 0, 0, 2, 0);
      drive(1, "B4", NOP, ADD, NOP, NOP, 3'b100, 0,
            0, RUN, 0, 0, 1, 3, 0);

      rst(1, "rstB2", 1'b0);
      drive(1, "I1", ADD, ADDI, NOP, NOP, 3'b100, 0,
            1, STL, 0, 0, 0, 0, 0);
      drive(1, "I2", ADD, NOP, ADDI, NOP, 3'b010, 0,
            1, STL, 0, 0, 0, 1, 0);
      rst(1, "rstI", 1'b0);
      drive(1, "I3", ADD, ADDI, NOP, NOP, 3'b100, 0,
            1, STL, 0, 0, 0, 0, 0);
      drive(1, "I4", ADD, NOP, ADDI, NOP, 3'b010, 0,
            1, STL, 0, 0, 0, 1, 0);
      drive(1, "I5", NOP, NOP, NOP, NOP, 3'b000, 0,
            0, RUN, 0, 0, 0, 2, 0);

      rst(2, "rstC", 1'b1);
      drive(2, "C1", ADD, ADDI, NOP, NOP, 3'b100, 0,
            0, RUN, 0, 0, 0, 0, 0);
      drive(2, "C2", NOP, ADD, ADDI, NOP, 3'b110, 0,
            0, RUN, 2'b01, 2'b01, 0, 0, 0);
      drive(2, "C3", NOP, ADD, ADDI, ADDI, 3'b111, 0,
            0, RUN, 2'b01, 2'b01, 0, 0, 0);
      drive(2, "C4", NOP, ADD, NOP, ADDI, 3'b101, 0,
            0, RUN, 2'b10, 2'b10, 0, 0, 0);

      rst(2, "rstD", 1'b0);
      drive(2, "D1", ADD, LW, NOP, NOP, 3'b100, 0,
            1, STL, 0, 0, 0, 0, 0);
      drive(2, "D2", ADD, NOP, LW, NOP, 3'b010, 0,
            0, RUN, 0, 0, 0, 1, 0);
      drive(2, "D3", NOP, ADD, NOP, LW, 3'b101, 0,
            0, RUN, 2'b10, 2'b10, 0, 1, 0);

      rst(2, "rstE", 1'b0);
      drive(2, "E1", ADD, LW, NOP, NOP, 3'b100, 1,
            1, FLS, 0, 0, 0, 0, 0);
      drive(2, "E2", NOP, NOP, NOP, NOP, 3'b000, 0,
            0, RUN, 0, 0, 0, 0, 1);

      rst(0, "rstF", 1'b0);
      drive(0, "F1", ADD0, ADDIX0, NOP, NOP, 3'b100, 0,
            0, RUN, 0, 0, 0, 0, 0);
      drive(2, "F2", NOP, ADD0, ADDIX0, NOP, 3'b110, 0,
            0, RUN, 0, 0, 0, 0, 0);
      drive(0, "F3", ADD0, NOP, ADDIX0, ADDIX0, 3'b011, 0,
            0, RUN, 0, 0, 0, 0, 0);

      rst(3, "rstG", 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(3, "G", NOP, NOP, NOP, NOP, 3'b000, 1,
               0, FLS, 0, 0, 0, 0, (i > 3) ? 3 : i);
      end
      drive(3, "G6", NOP, NOP, NOP, NOP, 3'b000, 0,
            0, RUN, 0, 0, 0, 0, 3);

      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d left want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
